// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: write-data source codes and wb_sched states
package cpu_pkg;

    localparam logic [2:0] SRC_IMM227 = 3'b000;
    localparam logic [2:0] SRC_LOAD   = 3'b001;
    localparam logic [2:0] SRC_ALU    = 3'b010;
    localparam logic [2:0] SRC_SHL    = 3'b011;
    localparam logic [2:0] SRC_HI     = 3'b100;
    localparam logic [2:0] SRC_LO     = 3'b101;
    localparam logic [2:0] SRC_SHR    = 3'b110;
    localparam logic [2:0] SRC_LT     = 3'b111;

    localparam logic [1:0] WB_IDLE     = 2'd0;
    localparam logic [1:0] WB_WAIT_MEM = 2'd1;
    localparam logic [1:0] WB_WAIT_MD  = 2'd2;
    localparam logic [1:0] WB_WRITE    = 2'd3;

    function automatic logic src_is_md(input logic [2:0] src);
        return (src == SRC_HI) || (src == SRC_LO);
    endfunction

endpackage

// File: rtl/wb_sched.sv
// rtl/wb_sched.sv - register-file write-back scheduler with load and mult/div wait handling
module wb_sched
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT   = 2,
    parameter int MD_TIMEOUT = 40,
    parameter int STALL_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_req,
    input  logic [2:0]         wb_src,
    input  logic [4:0]         wb_dst,
    input  logic               md_busy,
    input  logic               flush,
    output logic [2:0]         dataControl,
    output logic               regWrite,
    output logic [4:0]         regDst,
    output logic               wb_busy,
    output logic               wb_ack,
    output logic               wb_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [7:0] MEM_LOAD = 8'(MEM_WAIT - 1);
    localparam logic [7:0] MD_LAST  = 8'(MD_TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic [1:0] state_nxt;
    // One register serves as the load down-counter and the mult/div timeout up-counter.
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       accept;
    logic       md_timeout;
    logic       waiting;

    assign accept     = (state == WB_IDLE) && wb_req && !flush;
    assign md_timeout = (state == WB_WAIT_MD) && md_busy && (cnt == MD_LAST);
    assign waiting    = (state == WB_WAIT_MEM) || (state == WB_WAIT_MD);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (wb_src == SRC_LOAD) begin
                        state_nxt = WB_WAIT_MEM;
                        cnt_nxt   = MEM_LOAD;
                    end else if (src_is_md(wb_src)) begin
                        state_nxt = WB_WAIT_MD;
                        cnt_nxt   = 8'd0;
                    end else begin
                        state_nxt = WB_WRITE;
                    end
                end
            end
            WB_WAIT_MEM: begin
                if (cnt == 8'd0) begin
                    state_nxt = WB_WRITE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            WB_WAIT_MD: begin
                if (!md_busy) begin
                    state_nxt = WB_WRITE;
                end else if (md_timeout) begin
                    state_nxt = WB_IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            WB_WRITE: begin
                state_nxt = WB_IDLE;
            end
            default: begin
                state_nxt = WB_IDLE;
            end
        endcase
        // A squash abandons whatever is in flight.
        if (flush && (state != WB_IDLE)) begin
            state_nxt = WB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WB_IDLE;
            cnt         <= 8'd0;
            dataControl <= 3'd0;
            regDst      <= 5'd0;
            wb_err      <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                dataControl <= wb_src;
                regDst      <= wb_dst;
            end
            if (accept) begin
                wb_err <= 1'b0;
            end else if (md_timeout && !flush) begin
                wb_err <= 1'b1;
            end
            if (waiting && (stall_cnt != {STALL_W{1'b1}})) begin
                stall_cnt <= stall_cnt + STALL_ONE;
            end
        end
    end

    assign wb_busy  = (state != WB_IDLE);
    assign wb_ack   = !flush && ((state == WB_WRITE) || md_timeout);
    // Writes to register 0 complete as an ack without touching the register file.
    assign regWrite = !flush && (state == WB_WRITE) && (regDst != 5'd0);

endmodule

// File: tb/tb_wb_sched.sv
// tb/tb_wb_sched.sv - table-driven and scoreboarded bench for wb_sched
module tb_wb_sched;
    import cpu_pkg::*;

    localparam int MEM_WAIT   = 2;
    localparam int MD_TIMEOUT = 40;
    localparam int STALL_W    = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wb_req = 1'b0;
    logic [2:0]         wb_src = 3'd0;
    logic [4:0]         wb_dst = 5'd0;
    logic               md_busy = 1'b0;
    logic               flush = 1'b0;
    logic [2:0]         dataControl;
    logic               regWrite;
    logic [4:0]         regDst;
    logic               wb_busy;
    logic               wb_ack;
    logic               wb_err;
    logic [STALL_W-1:0] stall_cnt;

    wb_sched #(
        .MEM_WAIT  (MEM_WAIT),
        .MD_TIMEOUT(MD_TIMEOUT),
        .STALL_W   (STALL_W)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .wb_req     (wb_req),
        .wb_src     (wb_src),
        .wb_dst     (wb_dst),
        .md_busy    (md_busy),
        .flush      (flush),
        .dataControl(dataControl),
        .regWrite   (regWrite),
        .regDst     (regDst),
        .wb_busy    (wb_busy),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] src;
        logic [4:0] dst;
        int         md_n;
        int         lat;
        logic       wr;
        int         stall;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [2:0] src;
    } wr_t;

    int   n_vec = 0;
    int   n_bad = 0;
    wr_t  sb[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every register write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && regWrite) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected_write: got regDst=%0d dataControl=%0d expected no write",
                         regDst, dataControl);
            end else begin
                e = sb.pop_front();
                check("sb_dst", 32'(regDst), 32'(e.dst));
                check("sb_src", 32'(dataControl), 32'(e.src));
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int               t;
        int               lat;
        logic             wrote;
        logic [STALL_W-1:0] s0;
        @(posedge clk); #1;
        s0      = stall_cnt;
        wb_req  = 1'b1;
        wb_src  = v.src;
        wb_dst  = v.dst;
        md_busy = (v.md_n > 0);
        if (v.wr) sb.push_back({v.dst, v.src});
        t     = 0;
        lat   = -1;
        wrote = 1'b0;
        while (lat < 0 && t < 300) begin
            @(posedge clk); #1;
            wb_req  = 1'b0;
            t++;
            md_busy = (t <= v.md_n);
            @(negedge clk);
            if (regWrite) wrote = 1'b1;
            if (wb_ack) lat = t;
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_wrote", idx), 32'(wrote), 32'(v.wr));
        check($sformatf("v%0d_dataControl", idx), 32'(dataControl), 32'(v.src));
        check($sformatf("v%0d_regDst", idx), 32'(regDst), 32'(v.dst));
        @(posedge clk); #1;
        md_busy = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_busy_after", idx), 32'(wb_busy), 32'd0);
        check($sformatf("v%0d_err", idx), 32'(wb_err), 32'(v.err));
        check($sformatf("v%0d_stall_delta", idx), 32'(stall_cnt - s0), 32'(v.stall));
    endtask

    initial begin
        // src, dst, md busy cycles, ack latency, writes, stall delta, err after
        vecs[0]  = '{SRC_ALU,    5'd7,  0,   1,  1'b1, 0,  1'b0};
        vecs[1]  = '{SRC_LOAD,   5'd3,  0,   3,  1'b1, 2,  1'b0};
        vecs[2]  = '{SRC_HI,     5'd9,  10,  12, 1'b1, 11, 1'b0};
        vecs[3]  = '{SRC_LO,     5'd31, 0,   2,  1'b1, 1,  1'b0};
        vecs[4]  = '{SRC_HI,     5'd4,  255, 40, 1'b0, 40, 1'b1};
        vecs[5]  = '{SRC_SHR,    5'd0,  0,   1,  1'b0, 0,  1'b0};
        vecs[6]  = '{SRC_LO,     5'd12, 39,  41, 1'b1, 40, 1'b0};
        vecs[7]  = '{SRC_LO,     5'd13, 40,  40, 1'b0, 40, 1'b1};
        vecs[8]  = '{SRC_IMM227, 5'd1,  0,   1,  1'b1, 0,  1'b0};
        vecs[9]  = '{SRC_SHL,    5'd2,  0,   1,  1'b1, 0,  1'b0};
        vecs[10] = '{SRC_LT,     5'd30, 0,   1,  1'b1, 0,  1'b0};
        vecs[11] = '{SRC_LOAD,   5'd0,  0,   3,  1'b0, 2,  1'b0};

        #2;
        check("reset_outs", 32'({regWrite, wb_busy, wb_ack, wb_err, dataControl, regDst, stall_cnt}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted while a load is waiting clears everything immediately.
        @(posedge clk); #1;
        wb_req = 1'b1; wb_src = SRC_LOAD; wb_dst = 5'd3;
        @(posedge clk); #1;
        wb_req = 1'b0;
        check("rst_mid_busy", 32'(wb_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 32'({regWrite, wb_busy, wb_ack, wb_err, dataControl, regDst, stall_cnt}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_req = 1'b1; wb_src = SRC_ALU; wb_dst = 5'd5;
        sb.push_back({5'd5, SRC_ALU});
        @(posedge clk); #1;
        wb_req = 1'b0;
        @(negedge clk);
        check("rst_after_write", 32'(regWrite), 32'd1);
        check("rst_after_dst", 32'(regDst), 32'd5);

        // Flush during WAIT_MEM.
        @(posedge clk); #1;
        wb_req = 1'b1; wb_src = SRC_LOAD; wb_dst = 5'd3;
        @(posedge clk); #1;
        wb_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_mem_ack", 32'({regWrite, wb_ack}), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_mem_idle", 32'({wb_busy, wb_ack, regWrite}), 32'd0);
        repeat (4) @(posedge clk);

        // Flush in the WRITE cycle suppresses the write and the ack.
        @(posedge clk); #1;
        wb_req = 1'b1; wb_src = SRC_ALU; wb_dst = 5'd6;
        @(posedge clk); #1;
        wb_req = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_wr_ack", 32'({regWrite, wb_ack}), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_wr_idle", 32'(wb_busy), 32'd0);

        // A request held while busy is ignored.
        @(posedge clk); #1;
        wb_req = 1'b1; wb_src = SRC_LOAD; wb_dst = 5'd3;
        sb.push_back({5'd3, SRC_LOAD});
        @(posedge clk); #1;
        wb_src = SRC_ALU; wb_dst = 5'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_req = 1'b0;
        @(negedge clk);
        check("busy_ign_write", 32'({regWrite, wb_ack}), 32'd3);
        check("busy_ign_dst", 32'(regDst), 32'd3);
        check("busy_ign_src", 32'(dataControl), 32'(SRC_LOAD));
        @(posedge clk); #1;
        @(negedge clk);
        check("busy_ign_idle", 32'({wb_busy, regDst}), 32'd3);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
